// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MEM-stage data memory.
//   SZ_*        access size encodings carried on mem_size
//   state_t     controller states (CLEAR, READY)
//   be_gen      size + byte lane -> 4-bit byte enable
//   misaligned  size + byte lane -> access cannot be performed
package mips_mem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic {
      CLEAR,
      READY
   } state_t;

   function automatic logic [3:0] be_gen(input logic [1:0] size, input logic [1:0] lane);
      logic [3:0] be;
      be = 4'b0000;
      case (size)
         SZ_BYTE: be = 4'b0001 << lane;
         SZ_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
         SZ_WORD: be = 4'b1111;
         default: be = 4'b0000;
      endcase
      return be;
   endfunction

   // The reserved size code is reported as misaligned so that a single
   // error path covers every undecodable request.
   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
      logic bad;
      bad = 1'b0;
      case (size)
         SZ_BYTE: bad = 1'b0;
         SZ_HALF: bad = lane[0];
         SZ_WORD: bad = |lane;
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/dmem_align.sv
// Combinational lane steering for the data memory.
//   size   in  2   access size (mips_mem_pkg::SZ_*)
//   lane   in  2   byte address within the word
//   uns    in  1   zero-extend loads when 1, sign-extend when 0
//   wdata  in  32  right-justified store data
//   raw    in  32  word read from storage
//   wword  out 32  store data replicated onto every candidate lane
//   be     out 4   byte enables for the store
//   ldata  out 32  selected lane shifted to bit 0 and extended
module dmem_align
   import mips_mem_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  lane,
   input  logic        uns,
   input  logic [31:0] wdata,
   input  logic [31:0] raw,
   output logic [31:0] wword,
   output logic [3:0]  be,
   output logic [31:0] ldata
);

   // Replicating the datum onto all lanes lets the byte enables alone pick
   // the destination; no shifter is needed on the write side.
   function automatic logic [31:0] store_word(input logic [1:0] sz, input logic [31:0] d);
      logic [31:0] w;
      w = d;
      case (sz)
         SZ_BYTE: w = {4{d[7:0]}};
         SZ_HALF: w = {2{d[15:0]}};
         default: w = d;
      endcase
      return w;
   endfunction

   function automatic logic [31:0] load_ext(input logic [1:0] sz, input logic [1:0] ln,
                                            input logic u, input logic [31:0] r);
      logic [31:0] sh;
      logic [31:0] res;
      sh  = r >> {ln, 3'b000};
      res = 32'h0;
      case (sz)
         SZ_BYTE: res = u ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
         SZ_HALF: res = u ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
         SZ_WORD: res = r;
         default: res = 32'h0;
      endcase
      return res;
   endfunction

   always_comb begin
      wword = store_word(size, wdata);
      be    = be_gen(size, lane);
      ldata = load_ext(size, lane, uns, raw);
   end

endmodule

// File: rtl/data_mem_bytelane.sv
// Clocked byte-addressable data memory for the MEM stage.
//   clk        in  1   rising-edge clock
//   rst_n      in  1   synchronous active-low reset
//   mem_read   in  1   load request
//   mem_write  in  1   store request (wins over mem_read)
//   mem_size   in  2   00 byte, 01 half, 10 word, 11 reserved
//   mem_uns    in  1   zero-extend sub-word loads
//   addr       in  32  byte address
//   wdata      in  32  right-justified store data
//   rdata      out 32  registered load result, held until the next load
//   rvalid     out 1   one-cycle pulse with each accepted load
//   busy       out 1   reset or clear in progress, requests ignored
//   err        out 1   one-cycle pulse for a rejected request
//
// state | meaning
// CLEAR | zeroing one word per cycle at clr_idx, requests ignored
// READY | serving loads and stores
module data_mem_bytelane
   import mips_mem_pkg::*;
#(
   parameter int DEPTH      = 512,
   parameter bit CLEAR_INIT = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [1:0]  mem_size,
   input  logic        mem_uns,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        rvalid,
   output logic        busy,
   output logic        err
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

   logic [31:0] mem [DEPTH];

   state_t        state, state_nxt;
   logic [AW-1:0] clr_idx, clr_idx_nxt;

   logic [AW-1:0] widx;
   logic [1:0]    lane;
   logic          bad;
   logic          ready;
   logic          acc_store, acc_load, rej;

   logic [31:0]   wword, ldata;
   logic [3:0]    be;

   logic          we;
   logic [AW-1:0] waddr;
   logic [3:0]    wbe;
   logic [31:0]   wval;

   assign widx  = addr[AW+1:2];
   assign lane  = addr[1:0];
   assign bad   = (|addr[31:AW+2]) | misaligned(mem_size, lane);
   assign ready = rst_n & (state == READY);

   // A simultaneous read+write is a plain store; no load result is produced.
   assign acc_store = ready & mem_write & ~bad;
   assign acc_load  = ready & mem_read & ~mem_write & ~bad;
   assign rej       = ready & (mem_read | mem_write) & bad;

   assign busy = ~rst_n | (state == CLEAR);

   dmem_align u_align (
      .size  (mem_size),
      .lane  (lane),
      .uns   (mem_uns),
      .wdata (wdata),
      .raw   (mem[widx]),
      .wword (wword),
      .be    (be),
      .ldata (ldata)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= CLEAR_INIT ? CLEAR : READY;
         clr_idx <= '0;
      end else begin
         state   <= state_nxt;
         clr_idx <= clr_idx_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      clr_idx_nxt = clr_idx;
      case (state)
         CLEAR: begin
            clr_idx_nxt = clr_idx + AW'(1);
            if (clr_idx == LAST_IDX) begin
               state_nxt = READY;
            end
         end
         READY: state_nxt = READY;
         default: state_nxt = READY;
      endcase
   end

   // Single write port shared by the clear sequencer and stores.
   always_comb begin
      we    = rst_n & ((state == CLEAR) | acc_store);
      waddr = widx;
      wbe   = be;
      wval  = wword;
      if (state == CLEAR) begin
         waddr = clr_idx;
         wbe   = 4'b1111;
         wval  = 32'h0;
      end
   end

   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < 4; b++) begin
            if (wbe[b]) begin
               mem[waddr][8*b +: 8] <= wval[8*b +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rdata  <= 32'h0;
         rvalid <= 1'b0;
         err    <= 1'b0;
      end else begin
         rvalid <= acc_load;
         err    <= rej;
         if (acc_load) begin
            rdata <= ldata;
         end
      end
   end

endmodule

// File: tb/tb_data_mem_bytelane.sv
module tb_data_mem_bytelane;
   import mips_mem_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_read, mem_write, mem_uns;
   logic [1:0]  mem_size;
   logic [31:0] addr, wdata;
   logic [31:0] rdata;
   logic        rvalid, busy, err;

   int checks   = 0;
   int failures = 0;

   logic        o_rv, o_err;
   logic [31:0] o_rd;

   data_mem_bytelane #(.DEPTH(512), .CLEAR_INIT(1'b1)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .mem_size  (mem_size),
      .mem_uns   (mem_uns),
      .addr      (addr),
      .wdata     (wdata),
      .rdata     (rdata),
      .rvalid    (rvalid),
      .busy      (busy),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   task automatic idle();
      mem_read  = 1'b0;
      mem_write = 1'b0;
      mem_size  = SZ_WORD;
      mem_uns   = 1'b0;
      addr      = 32'h0;
      wdata     = 32'h0;
   endtask

   task automatic op(input logic rd, input logic wr, input logic [1:0] sz, input logic u,
                     input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      mem_read  = rd;
      mem_write = wr;
      mem_size  = sz;
      mem_uns   = u;
      addr      = a;
      wdata     = d;
      @(posedge clk);
      #1;
      o_rv  = rvalid;
      o_err = err;
      o_rd  = rdata;
      idle();
   endtask

   task automatic load_chk(input string tag, input logic [1:0] sz, input logic u,
                           input logic [31:0] a, input logic [31:0] exp);
      op(1'b1, 1'b0, sz, u, a, 32'h0);
      check({tag, "_rvalid"}, {31'h0, o_rv}, 32'd1);
      check({tag, "_err"}, {31'h0, o_err}, 32'd0);
      check({tag, "_rdata"}, o_rd, exp);
      @(posedge clk);
      #1;
      check({tag, "_pulse"}, {31'h0, rvalid}, 32'd0);
   endtask

   task automatic store(input string tag, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] d);
      op(1'b0, 1'b1, sz, 1'b0, a, d);
      check({tag, "_err"}, {31'h0, o_err}, 32'd0);
      check({tag, "_rvalid"}, {31'h0, o_rv}, 32'd0);
   endtask

   task automatic err_chk(input string tag, input logic rd, input logic wr,
                          input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
      op(rd, wr, sz, 1'b0, a, d);
      check({tag, "_err"}, {31'h0, o_err}, 32'd1);
      check({tag, "_rvalid"}, {31'h0, o_rv}, 32'd0);
      @(posedge clk);
      #1;
      check({tag, "_err_pulse"}, {31'h0, err}, 32'd0);
   endtask

   // Called right after rst_n rises; counts cycles until busy drops.
   task automatic wait_clear(output int cnt, output logic saw_rv, output logic saw_err,
                             input int inject_at);
      cnt     = 0;
      saw_rv  = 1'b0;
      saw_err = 1'b0;
      while (busy && cnt < 2000) begin
         mem_write = (cnt == inject_at);
         mem_read  = (cnt == inject_at + 1);
         mem_size  = SZ_WORD;
         addr      = 32'h48;
         wdata     = 32'hFFFF_FFFF;
         @(posedge clk);
         #1;
         cnt++;
         if (rvalid) saw_rv = 1'b1;
         if (err) saw_err = 1'b1;
      end
      idle();
   endtask

   int   cnt;
   logic saw_rv, saw_err;

   initial begin
      rst_n = 1'b0;
      idle();
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", {31'h0, busy}, 32'd1);
      check("rst_rvalid", {31'h0, rvalid}, 32'd0);
      check("rst_err", {31'h0, err}, 32'd0);
      check("rst_rdata", rdata, 32'h0);

      @(negedge clk);
      rst_n = 1'b1;
      wait_clear(cnt, saw_rv, saw_err, -10);
      check("clear_cycles", cnt, 32'd512);

      load_chk("lw_7fc", SZ_WORD, 1'b0, 32'h7FC, 32'h0);

      store("sw_10", SZ_WORD, 32'h10, 32'h1122_3344);
      store("sb_11", SZ_BYTE, 32'h11, 32'h1234_56AA);
      load_chk("lw_10", SZ_WORD, 1'b0, 32'h10, 32'h1122_AA44);
      load_chk("lb_11", SZ_BYTE, 1'b0, 32'h11, 32'hFFFF_FFAA);
      load_chk("lbu_11", SZ_BYTE, 1'b1, 32'h11, 32'h0000_00AA);
      load_chk("lbu_13", SZ_BYTE, 1'b1, 32'h13, 32'h0000_0011);

      store("sh_22", SZ_HALF, 32'h22, 32'hDEAD_8001);
      load_chk("lh_22", SZ_HALF, 1'b0, 32'h22, 32'hFFFF_8001);
      load_chk("lhu_22", SZ_HALF, 1'b1, 32'h22, 32'h0000_8001);
      load_chk("lw_20", SZ_WORD, 1'b0, 32'h20, 32'h8001_0000);
      load_chk("lh_20", SZ_HALF, 1'b0, 32'h20, 32'h0000_0000);

      err_chk("lw_13", 1'b1, 1'b0, SZ_WORD, 32'h13, 32'h0);
      err_chk("lh_21", 1'b1, 1'b0, SZ_HALF, 32'h21, 32'h0);
      err_chk("sz_11", 1'b1, 1'b0, 2'b11, 32'h10, 32'h0);
      err_chk("oor_800", 1'b1, 1'b0, SZ_WORD, 32'h800, 32'h0);
      err_chk("sw_12", 1'b0, 1'b1, SZ_WORD, 32'h12, 32'hFFFF_FFFF);
      err_chk("sw_810", 1'b0, 1'b1, SZ_WORD, 32'h810, 32'hFFFF_FFFF);
      err_chk("sw_sz11", 1'b0, 1'b1, 2'b11, 32'h10, 32'hFFFF_FFFF);
      load_chk("lw_10_kept", SZ_WORD, 1'b0, 32'h10, 32'h1122_AA44);

      // Store at edge N, load issued in cycle N+1.
      @(negedge clk);
      mem_write = 1'b1;
      mem_size  = SZ_WORD;
      addr      = 32'h40;
      wdata     = 32'hCAFE_F00D;
      @(negedge clk);
      mem_write = 1'b0;
      mem_read  = 1'b1;
      @(posedge clk);
      #1;
      check("raw_rvalid", {31'h0, rvalid}, 32'd1);
      check("raw_rdata", rdata, 32'hCAFE_F00D);
      idle();

      op(1'b1, 1'b1, SZ_WORD, 1'b0, 32'h44, 32'h5A5A_1234);
      check("rw_rvalid", {31'h0, o_rv}, 32'd0);
      check("rw_err", {31'h0, o_err}, 32'd0);
      check("rdata_hold", o_rd, 32'hCAFE_F00D);
      load_chk("lw_44", SZ_WORD, 1'b0, 32'h44, 32'h5A5A_1234);

      // Load coinciding with a reset edge is discarded.
      @(negedge clk);
      rst_n    = 1'b0;
      mem_read = 1'b1;
      mem_size = SZ_WORD;
      addr     = 32'h10;
      @(posedge clk);
      #1;
      check("rst_discard_rvalid", {31'h0, rvalid}, 32'd0);
      check("rst_discard_rdata", rdata, 32'h0);
      idle();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (100) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      wait_clear(cnt, saw_rv, saw_err, 500);
      check("reclear_cycles", cnt, 32'd512);
      check("reclear_rvalid", {31'h0, saw_rv}, 32'd0);
      check("reclear_err", {31'h0, saw_err}, 32'd0);

      load_chk("lw_10_cleared", SZ_WORD, 1'b0, 32'h10, 32'h0);
      load_chk("lw_44_cleared", SZ_WORD, 1'b0, 32'h44, 32'h0);
      load_chk("lw_48_ignored", SZ_WORD, 1'b0, 32'h48, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
